seq_alu: RTL and testbench

- Parametrised multi-cycle ALU with a registered bgn/rdy handshake.
- Operand width is set by WIDTH. Shift, rotate and logic ops are carried over; MUL (shift-add), DIV and MOD (restoring) are new and iterative.
- All results and flags are registered and held until the next completion.
- Sits between the register file and the control FSM, which starts an operation and waits for rdy.

---
 rtl/seq_alu_if.sv | 23 ++
 rtl/seq_alu.sv | 161 ++++++++++++++++
 tb/tb_seq_alu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: start/operand and result/flag/handshake bundle for seq_alu
interface seq_alu_if #(parameter int WIDTH = 16);
  logic             bgn;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc1;
  logic [WIDTH-1:0] acc2;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             busy;
  logic             rdy;
  modport master (
    output bgn, opcode, a, b,
    input  acc1, acc2, zero, negative, carry, overflow, busy, rdy
  );
  modport slave (
    input  bgn, opcode, a, b,
    output acc1, acc2, zero, negative, carry, overflow, busy, rdy
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with bgn/rdy handshake; define SEQ_ALU_BARREL_EN for single-cycle rotates
module seq_alu #(
  parameter int WIDTH = 16
) (
  input logic     clk,
  input logic     rst,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_LSR = 5'h03, OP_LSL = 5'h04,
                         OP_RSR = 5'h05, OP_RSL = 5'h06, OP_MUL = 5'h07, OP_DIV = 5'h08,
                         OP_MOD = 5'h09, OP_AND = 5'h0A, OP_OR  = 5'h0B, OP_XOR = 5'h0C,
                         OP_NOT = 5'h0D, OP_CMP = 5'h0E, OP_TST = 5'h0F, OP_INC = 5'h10,
                         OP_DEC = 5'h11;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           state, next_state;
  logic [4:0]       op;
  logic [WIDTH-1:0] ra, rb, wh, wl;
  logic [CW-1:0]    cnt, load, rot_cnt;
  logic [WIDTH-1:0] acc1, acc2;
  logic             zero, negative, carry, overflow;
  logic             last, is_div, start;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ok;
  logic [WIDTH-1:0] div_tr, step_h, step_l, rot_res;
  logic [WIDTH-1:0] y, res1, res2, val;
  logic [WIDTH:0]   sum, lsr_t, lsl_t;
  logic             sub, ovf, c, v, z, n, wr_acc, wr_flag;
  assign start  = state == IDLE && bus.bgn;
  assign last   = cnt <= CW'(1);
  assign is_div = op == OP_DIV || op == OP_MOD;
  assign load   = (bus.opcode == OP_MUL || bus.opcode == OP_DIV || bus.opcode == OP_MOD) ? CW'(WIDTH) :
                  (bus.opcode == OP_RSR || bus.opcode == OP_RSL) ? rot_cnt : CW'(1);
`ifdef SEQ_ALU_BARREL_EN
  logic [CW-1:0] rmod;
  assign rmod    = CW'(rb % WIDTH);
  assign rot_res = op == OP_RSR ? (ra >> rmod) | (ra << (CW'(WIDTH) - rmod))
                                : (ra << rmod) | (ra >> (CW'(WIDTH) - rmod));
  assign rot_cnt = CW'(1);
`else
  assign rot_res = step_l;
  assign rot_cnt = CW'(bus.b % WIDTH);
`endif
  assign bus.acc1     = acc1;
  assign bus.acc2     = acc2;
  assign bus.zero     = zero;
  assign bus.negative = negative;
  assign bus.carry    = carry;
  assign bus.overflow = overflow;
  assign bus.busy     = state == EXEC;
  assign bus.rdy      = state == DONE;
  // State register; a reset mid-operation drops straight back to IDLE
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end
  // Next state: EXEC runs until the iteration counter reaches its last step
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = bus.bgn ? EXEC : IDLE;
      EXEC:    next_state = last ? DONE : EXEC;
      default: next_state = IDLE;
    endcase
  end
  // One iteration step: shift-add multiply, restoring divide, or one-bit rotate
  always_comb begin
    mul_sum = {1'b0, wh} + (wl[0] ? {1'b0, ra} : '0);
    div_sh  = {wh, wl[WIDTH-1]};
    div_ok  = div_sh >= {1'b0, rb};
    div_tr  = div_sh[WIDTH-1:0] - rb;
    step_h  = wh;
    step_l  = wl;
    if (op == OP_MUL) {step_h, step_l} = {mul_sum, wl[WIDTH-1:1]};
    else if (is_div) begin
      step_h = div_ok ? div_tr : div_sh[WIDTH-1:0];
      step_l = {wl[WIDTH-2:0], div_ok};
    end
    else if (op == OP_RSR && cnt != '0) step_l = {wl[0], wl[WIDTH-1:1]};
    else if (op == OP_RSL && cnt != '0) step_l = {wl[WIDTH-2:0], wl[WIDTH-1]};
  end
  // Result and flag values committed on the final EXEC step
  always_comb begin
    y       = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : rb;
    sub     = op == OP_SUB || op == OP_CMP || op == OP_DEC;
    sum     = sub ? {1'b0, ra} - {1'b0, y} : {1'b0, ra} + {1'b0, y};
    ovf     = (sub ? ra[WIDTH-1] != y[WIDTH-1] : ra[WIDTH-1] == y[WIDTH-1]) && sum[WIDTH-1] != ra[WIDTH-1];
    lsr_t   = {ra, 1'b0} >> rb;
    lsl_t   = {1'b0, ra} << rb;
    res1    = acc1;
    res2    = '0;
    c       = 1'b0;
    v       = 1'b0;
    wr_acc  = 1'b1;
    wr_flag = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        res1 = sum[WIDTH-1:0];
        c    = sum[WIDTH];
        v    = ovf;
      end
      OP_CMP: begin
        wr_acc = 1'b0;
        c      = sum[WIDTH];
        v      = ovf;
      end
      OP_LSR:         {res1, c} = lsr_t;
      OP_LSL:         {c, res1} = lsl_t;
      OP_RSR, OP_RSL: res1 = rot_res;
      OP_MUL:         {res2, res1} = {step_h, step_l};
      OP_DIV, OP_MOD: begin
        {res2, res1} = {step_h, step_l};
        v            = rb == '0;
      end
      OP_AND:         res1 = ra & rb;
      OP_OR:          res1 = ra | rb;
      OP_XOR:         res1 = ra ^ rb;
      OP_NOT:         res1 = ~ra;
      OP_TST:         wr_acc = 1'b0;
      default: begin
        wr_acc  = 1'b0;
        wr_flag = 1'b0;
      end
    endcase
    val = op == OP_CMP ? sum[WIDTH-1:0] : op == OP_TST ? ra & rb : res1;
    z   = val == '0 && res2 == '0;
    n   = op == OP_MUL ? res2[WIDTH-1] : val[WIDTH-1];
  end
  // Datapath: latch operands on start, iterate in EXEC, commit on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      acc1     <= '0;
      acc2     <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      op  <= bus.opcode;
      ra  <= bus.a;
      rb  <= bus.b;
      cnt <= load;
      wh  <= '0;
      wl  <= bus.opcode == OP_MUL ? bus.b : bus.a;
    end else if (state == EXEC) begin
      cnt <= cnt - CW'(1);
      wh  <= step_h;
      wl  <= step_l;
      if (last && wr_acc) begin
        acc1 <= res1;
        acc2 <= res2;
      end
      if (last && wr_flag) begin
        zero     <= z;
        negative <= n;
        carry    <= c;
        overflow <= v;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu
module tb_seq_alu;
  localparam int W = 16;
  localparam logic [4:0] OP_ADD = 5'h01, OP_SUB = 5'h02, OP_LSR = 5'h03, OP_LSL = 5'h04,
                         OP_RSR = 5'h05, OP_RSL = 5'h06, OP_MUL = 5'h07, OP_DIV = 5'h08,
                         OP_MOD = 5'h09, OP_AND = 5'h0A, OP_OR  = 5'h0B, OP_XOR = 5'h0C,
                         OP_NOT = 5'h0D, OP_CMP = 5'h0E, OP_TST = 5'h0F, OP_INC = 5'h10,
                         OP_DEC = 5'h11, OP_NOP = 5'h1F;
`ifdef SEQ_ALU_BARREL_EN
  localparam int RLAT = 2;
`else
  localparam int RLAT = 5;
`endif
  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b, r1, r2;
    logic [3:0]  fl;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  seq_alu_if #(.WIDTH(W)) bus();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [3:0] fl;
  assign fl = {bus.zero, bus.negative, bus.carry, bus.overflow};
  vec_t vecs [28] = '{
    '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0101, 2},
    '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110, 2},
    '{OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0000, 17},
    '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b0100, 17},
    '{OP_DIV, 16'd100,  16'd7,    16'h000E, 16'h0002, 4'b0000, 17},
    '{OP_DIV, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 4'b0101, 17},
    '{OP_MOD, 16'd100,  16'd7,    16'h000E, 16'h0002, 4'b0000, 17},
    '{OP_RSL, 16'h8001, 16'h0001, 16'h0003, 16'h0000, 4'b0000, 2},
    '{OP_RSR, 16'h0001, 16'd20,   16'h1000, 16'h0000, 4'b0000, RLAT},
    '{OP_RSR, 16'h1234, 16'h0010, 16'h1234, 16'h0000, 4'b0000, 2},
    '{OP_RSL, 16'h1234, 16'h0004, 16'h2341, 16'h0000, 4'b0000, RLAT},
    '{OP_LSL, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0010, 2},
    '{OP_LSR, 16'h8000, 16'h0010, 16'h0000, 16'h0000, 4'b1010, 2},
    '{OP_LSR, 16'h0005, 16'h0000, 16'h0005, 16'h0000, 4'b0000, 2},
    '{OP_INC, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 4'b1010, 2},
    '{OP_DEC, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0110, 2},
    '{OP_DEC, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 4'b0001, 2},
    '{OP_AND, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 4'b0100, 2},
    '{OP_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 4'b0000, 2},
    '{OP_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0, 16'h0000, 4'b0000, 2},
    '{OP_NOT, 16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 4'b0100, 2},
    '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1010, 2},
    '{OP_TST, 16'h80F0, 16'h8000, 16'h0000, 16'h0000, 4'b0100, 2},
    '{OP_NOP, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 4'b0100, 2},
    '{OP_CMP, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 4'b0110, 2},
    '{5'h15,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110, 2},
    '{OP_MUL, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 17},
    '{OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001, 2}
  };
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     output int lat, output int bz);
    @(negedge clk);
    bus.bgn    = 1'b1;
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
    lat        = 0;
    bz         = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy) bz++;
      bus.bgn    = !bus.rdy;
      bus.opcode = OP_NOT;
      bus.a      = ~a;
      bus.b      = b ^ 16'h5A5A;
    end while (!bus.rdy && lat < 40);
    bus.bgn = 1'b0;
  endtask
  initial begin
    int lat, bz, rcnt;
    logic [15:0] rm, bm;
    bus.bgn    = 1'b0;
    bus.opcode = '0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(negedge clk);
    check("reset acc1", bus.acc1, 0);
    check("reset acc2", bus.acc2, 0);
    check("reset flags", fl, 0);
    check("reset busy", bus.busy, 0);
    check("reset rdy", bus.rdy, 0);
    rst = 1'b0;
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, lat, bz);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy cycles", i), bz, vecs[i].lat - 1);
      check($sformatf("v%0d acc1", i), bus.acc1, vecs[i].r1);
      check($sformatf("v%0d acc2", i), bus.acc2, vecs[i].r2);
      check($sformatf("v%0d flags", i), fl, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d rdy pulse", i), bus.rdy, 0);
    end
    @(negedge clk);
    bus.bgn    = 1'b1;
    bus.opcode = OP_MUL;
    bus.a      = 16'h1234;
    bus.b      = 16'h0100;
    repeat (5) begin
      @(negedge clk);
      bus.bgn = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort acc1", bus.acc1, 0);
    check("abort acc2", bus.acc2, 0);
    check("abort flags", fl, 0);
    check("abort busy", bus.busy, 0);
    check("abort rdy", bus.rdy, 0);
    rcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.rdy) rcnt++;
    end
    check("abort no rdy", rcnt, 0);
    run(OP_SUB, 16'd3, 16'd5, lat, bz);
    check("sub latency", lat, 2);
    check("sub acc1", bus.acc1, 16'hFFFE);
    check("sub flags", fl, 4'b0110);
    @(negedge clk);
    bus.bgn    = 1'b1;
    bus.opcode = OP_CMP;
    bus.a      = 16'h00AA;
    bus.b      = 16'h00AA;
    rm = '0;
    bm = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.rdy) rm |= 16'(1) << i;
      if (bus.busy) bm |= 16'(1) << i;
    end
    bus.bgn = 1'b0;
    check("cmp rdy cycles", rm, 16'h0924);
    check("cmp busy cycles", bm, 16'h0492);
    check("cmp acc1", bus.acc1, 16'hFFFE);
    check("cmp acc2", bus.acc2, 16'h0000);
    check("cmp flags", fl, 4'b1000);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
